// File: rtl/ifetch.sv
// ifetch: instruction fetch stage; owns the fetch PC and buffers {pc, inst} words for the decoder.
// Latency: request accepted in N, response in N+k (k>=1), inst_valid in N+k+1 (responses are registered).
// Backpressure: requests are credit-limited so outstanding + buffered never exceeds FIFO_DEPTH.
//
// Ports:
//   clock, reset_n                      - single clock, synchronous active-low reset
//   imem_req_valid/addr/ready           - word fetch requests (addr always 4-aligned)
//   imem_resp_valid/data                - in-order instruction words from memory
//   redirect, redirect_pc               - flush buffer, drop in-flight responses, restart at redirect_pc
//   inst_valid/inst/inst_pc/inst_ready  - buffer head presented to the decoder
//   misalign                            - only with IFETCH_MISALIGN_EN: sticky misaligned-redirect halt
//
// Optional feature macro: IFETCH_MISALIGN_EN. When undefined, redirect_pc[1:0] is ignored and the
// stage never halts.
module ifetch #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
`ifdef IFETCH_MISALIGN_EN
   ,
   output logic            misalign
`endif
);

   localparam int              AW      = $clog2(FIFO_DEPTH);
   localparam int              CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } fetch_entry_t;

   fetch_entry_t    buf_mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   outstanding_q;
   logic [CW-1:0]   discard_q;
   logic [XLEN-1:0] pc_q;
   // PC of the next response that will be kept. Responses return in order and requests
   // are sequential from the last restart point, so this simply walks forward by 4.
   logic [XLEN-1:0] resp_pc_q;

   logic            halted;
   logic [XLEN-1:0] target_pc;
   logic            pop;
   logic            push;
   logic            resp_drop;
   logic            req_accept;
   logic [CW:0]     in_use;
   logic [CW-1:0]   accept_w;
   logic [CW-1:0]   resp_w;
   logic [CW-1:0]   push_w;
   logic [CW-1:0]   pop_w;

`ifdef IFETCH_MISALIGN_EN
   logic halted_q;

   // Sticky until the next aligned redirect or reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         halted_q <= 1'b0;
      end else if (redirect) begin
         halted_q <= (redirect_pc[1:0] != 2'b00);
      end
   end

   assign halted   = halted_q;
   assign misalign = halted_q;
`else
   logic unused_redirect_lsbs;

   assign halted               = 1'b0;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

   assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

   assign inst_valid = (count_q != '0);
   assign inst       = buf_mem[rd_ptr_q].inst;
   assign inst_pc    = buf_mem[rd_ptr_q].pc;
   assign pop        = inst_valid & inst_ready;

   // A head entry leaving this cycle frees its slot immediately, which is what lets a
   // 1-cycle memory stream one instruction per cycle. Since outstanding + count can only
   // fall while a request waits, a raised request stays raised until accepted.
   assign in_use = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};

   assign imem_req_valid = reset_n & ~redirect & ~halted & (in_use < DEPTH_W);
   assign imem_req_addr  = pc_q;
   assign req_accept     = imem_req_valid & imem_req_ready;

   assign push      = imem_resp_valid & (discard_q == '0);
   assign resp_drop = imem_resp_valid & (discard_q != '0);

   assign accept_w = {{(CW-1){1'b0}}, req_accept};
   assign resp_w   = {{(CW-1){1'b0}}, imem_resp_valid};
   assign push_w   = {{(CW-1){1'b0}}, push};
   assign pop_w    = {{(CW-1){1'b0}}, pop};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (redirect) begin
         // Every response still owed by memory belongs to the old stream; one arriving
         // right now is dropped on the spot, the rest are counted off as they return.
         pc_q          <= target_pc;
         resp_pc_q     <= target_pc;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= outstanding_q - resp_w;
         discard_q     <= outstanding_q - resp_w;
      end else begin
         if (req_accept) begin
            pc_q <= pc_q + PC_STEP;
         end
         if (push) begin
            wr_ptr_q  <= wr_ptr_q + AW'(1);
            resp_pc_q <= resp_pc_q + PC_STEP;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (resp_drop) begin
            discard_q <= discard_q - CW'(1);
         end
         count_q       <= count_q + push_w - pop_w;
         outstanding_q <= outstanding_q + accept_w - resp_w;
      end
   end

   // Buffer storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clock) begin
      if (reset_n && !redirect && push) begin
         buf_mem[wr_ptr_q] <= '{pc: resp_pc_q, inst: imem_resp_data};
      end
   end

endmodule

// File: tb/tb_ifetch.sv
`timescale 1ns/1ps
module tb_ifetch;
   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h100;

   logic        clock = 1'b0;
   logic        reset_n, imem_req_valid, imem_req_ready, imem_resp_valid;
   logic        redirect, inst_valid, inst_ready;
   logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, inst, inst_pc;
`ifdef IFETCH_MISALIGN_EN
   logic        misalign;
`endif

   always #5 clock = ~clock;

   ifetch #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IFETCH_MISALIGN_EN
      , .misalign(misalign)
`endif
   );

   // Memory-side view: each accepted request and whether it was orphaned by a redirect.
   typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit stale; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ient_t;

   mreq_t       mem_q[$];
   ient_t       fifo_q[$];
   logic [31:0] m_pc;
   bit          m_halted;
   int          cyc, last_due, lat_min, lat_max;
   bit          data_is_addr;
   int          checks, errors;

   logic        s_rv, s_iv, s_acc;
   logic [31:0] s_ra, s_i, s_ip;
   bit          e_rv, e_iv, e_pop;
   logic [31:0] e_ra, e_i, e_ip;
`ifdef IFETCH_MISALIGN_EN
   logic        s_mis;
   bit          e_mis;
`endif

   // One clock: sample outputs mid-cycle, form expectations from the reference state,
   // advance the reference, then drive the memory response for the next cycle.
   task automatic tick();
      mreq_t r;
      int    d;
      @(negedge clock);
      s_rv = imem_req_valid; s_ra = imem_req_addr;
      s_iv = inst_valid;     s_i  = inst;          s_ip = inst_pc;
`ifdef IFETCH_MISALIGN_EN
      s_mis = misalign;
      e_mis = m_halted;
`endif
      e_iv  = fifo_q.size() != 0;
      e_ip  = e_iv ? fifo_q[0].pc : 32'h0;
      e_i   = e_iv ? fifo_q[0].inst : 32'h0;
      e_pop = e_iv && inst_ready;
      e_rv  = reset_n && !redirect && !m_halted &&
              (mem_q.size() + fifo_q.size() - int'(e_pop) < DEPTH);
      e_ra  = m_pc;
      s_acc = s_rv && imem_req_ready;
      if (!reset_n) begin
         mem_q.delete(); fifo_q.delete();
         m_pc = RPC; m_halted = 1'b0; last_due = 0;
      end else if (redirect) begin
         fifo_q.delete();
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         if (imem_resp_valid && mem_q.size() > 0) r = mem_q.pop_front();
         m_pc = {redirect_pc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_EN
         m_halted = (redirect_pc[1:0] != 2'b00);
`endif
      end else begin
         if (e_pop) void'(fifo_q.pop_front());
         if (imem_resp_valid && mem_q.size() > 0) begin
            r = mem_q.pop_front();
            if (!r.stale) fifo_q.push_back('{pc: r.addr, inst: r.data});
         end
         if (s_acc) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{addr: s_ra, data: data_is_addr ? s_ra : $urandom, due: d, stale: 1'b0});
         end
         if (e_rv && imem_req_ready) m_pc = m_pc + 32'd4;
      end
      cyc++;
      @(posedge clock);
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1; imem_resp_data = mem_q[0].data;
      end else begin
         imem_resp_valid = 1'b0; imem_resp_data = $urandom;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      imem_req_ready = 1'b1; inst_ready = 1'b1; lat_min = 1; lat_max = 1; data_is_addr = 1'b1;
      reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      checks++;
      if (s_rv !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b want=0", s_rv); end
      checks++;
      if (s_iv !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b want=0", s_iv); end
`ifdef IFETCH_MISALIGN_EN
      checks++;
      if (s_mis !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b want=0", s_mis); end
`endif
      reset_n = 1'b1;
      tick();
      checks++;
      if (s_rv !== 1'b1 || s_ra !== RPC)
         begin errors++; $display("FAIL release_req got=%b/%h want=1/%h", s_rv, s_ra, RPC); end
   endtask

   task automatic test_stream();
      logic [31:0] want;
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         tick();
         checks++;
         if (s_rv !== e_rv || (e_rv && s_ra !== e_ra))
            begin errors++; $display("FAIL stream_req c=%0d got=%b/%h want=%b/%h", c, s_rv, s_ra, e_rv, e_ra); end
         if (c >= 3) begin
            want = RPC + 32'(4 * (c - 3));
            checks++;
            if (s_iv !== 1'b1 || s_ip !== want || s_i !== want)
               begin errors++; $display("FAIL stream_inst c=%0d got=%b pc=%h inst=%h want pc=inst=%h", c, s_iv, s_ip, s_i, want); end
         end
      end
   endtask

   task automatic test_backpressure();
      int n, got, lastc;
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b0; imem_req_ready = 1'b1;
      do_reset();
      n = 0;
      for (int c = 0; c < 10; c++) begin tick(); if (s_acc) n++; end
      checks++;
      if (n != 2) begin errors++; $display("FAIL bp_req_count got=%0d want=2", n); end
      checks++;
      if (s_rv !== 1'b0) begin errors++; $display("FAIL bp_req_valid got=%b want=0", s_rv); end
      inst_ready = 1'b1;
      got = 0; lastc = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         tick();
         if (s_iv === 1'b1) begin
            checks++;
            if (s_ip !== RPC + 32'(4 * got) || (got > 0 && cyc != lastc + 1))
               begin errors++; $display("FAIL bp_drain n=%0d got=%h want=%h gap=%0d", got, s_ip, RPC + 32'(4 * got), cyc - lastc); end
            got++; lastc = cyc;
         end
      end
      checks++;
      if (got != 3) begin errors++; $display("FAIL bp_drain_timeout got=%0d want=3", got); end
   endtask

   task automatic test_req_stall();
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      tick();
      imem_req_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (s_rv !== 1'b1 || s_ra !== 32'h104)
            begin errors++; $display("FAIL stall_hold c=%0d got=%b/%h want=1/00000104", c, s_rv, s_ra); end
      end
      imem_req_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (s_rv !== 1'b1 || s_ra !== 32'h108)
         begin errors++; $display("FAIL stall_advance got=%b/%h want=1/00000108", s_rv, s_ra); end
   endtask

   task automatic test_redirect_stale();
      int got;
      lat_min = 3; lat_max = 3; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h400;
      tick();
      checks++;
      if (s_rv !== 1'b0) begin errors++; $display("FAIL redir_req_valid got=%b want=0", s_rv); end
      redirect = 1'b0;
      got = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         checks++;
         if (s_rv !== e_rv || (e_rv && s_ra !== e_ra))
            begin errors++; $display("FAIL redir_req c=%0d got=%b/%h want=%b/%h", c, s_rv, s_ra, e_rv, e_ra); end
         if (s_iv === 1'b1) begin
            checks++;
            if (s_ip !== 32'h400 + 32'(4 * got) || s_i !== s_ip)
               begin errors++; $display("FAIL redir_inst n=%0d got=%h/%h want=%h", got, s_ip, s_i, 32'h400 + 32'(4 * got)); end
            got++;
         end
      end
      checks++;
      if (got < 3) begin errors++; $display("FAIL redir_progress got=%0d want>=3", got); end
   endtask

   task automatic test_redirect_same_cycle();
      int c;
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      tick(); tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h800;
      tick();
      checks++;
      if (s_iv !== 1'b1 || s_ip !== 32'h104)
         begin errors++; $display("FAIL same_head got=%b/%h want=1/00000104", s_iv, s_ip); end
      redirect = 1'b0;
      tick();
      checks++;
      if (s_iv !== 1'b0) begin errors++; $display("FAIL same_flush got=%b want=0", s_iv); end
      checks++;
      if (s_rv !== 1'b1 || s_ra !== 32'h800)
         begin errors++; $display("FAIL same_restart got=%b/%h want=1/00000800", s_rv, s_ra); end
      c = 0;
      while (c < 10 && s_iv !== 1'b1) begin tick(); c++; end
      checks++;
      if (s_iv !== 1'b1 || s_ip !== 32'h800)
         begin errors++; $display("FAIL same_first got=%b/%h want=1/00000800", s_iv, s_ip); end
   endtask

   task automatic test_wrap();
      logic [31:0] wantv [3];
      int got;
      wantv[0] = 32'hFFFF_FFF8; wantv[1] = 32'hFFFF_FFFC; wantv[2] = 32'h0;
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      tick();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      got = 0;
      for (int c = 0; c < 15 && got < 3; c++) begin
         tick();
         if (s_iv === 1'b1) begin
            checks++;
            if (s_ip !== wantv[got])
               begin errors++; $display("FAIL wrap_pc n=%0d got=%h want=%h", got, s_ip, wantv[got]); end
            got++;
         end
      end
      checks++;
      if (got != 3) begin errors++; $display("FAIL wrap_timeout got=%0d want=3", got); end
   endtask

`ifdef IFETCH_MISALIGN_EN
   task automatic test_misalign();
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      tick(); tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h402;
      tick();
      redirect = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (s_mis !== 1'b1 || s_rv !== 1'b0 || s_iv !== 1'b0)
            begin errors++; $display("FAIL mis_halt c=%0d got mis=%b req=%b iv=%b want 1/0/0", c, s_mis, s_rv, s_iv); end
      end
      redirect = 1'b1; redirect_pc = 32'h500;
      tick();
      redirect = 1'b0;
      tick();
      checks++;
      if (s_mis !== 1'b0 || s_rv !== 1'b1 || s_ra !== 32'h500)
         begin errors++; $display("FAIL mis_resume got mis=%b req=%b/%h want 0/1/00000500", s_mis, s_rv, s_ra); end
   endtask
`else
   task automatic test_align_force();
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
      do_reset();
      tick(); tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h603;
      tick();
      redirect = 1'b0;
      tick();
      checks++;
      if (s_rv !== 1'b1 || s_ra !== 32'h600)
         begin errors++; $display("FAIL align_force got=%b/%h want=1/00000600", s_rv, s_ra); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] rp;
      lat_min = 1; lat_max = 4; data_is_addr = 1'b0;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         inst_ready     = ($urandom_range(0, 3) != 0);
         reset_n        = ($urandom_range(0, 599) != 0);
         redirect       = ($urandom_range(0, 24) == 0);
         rp = $urandom & 32'h0000_0FFC;
         if ($urandom_range(0, 9) == 0) rp = 32'hFFFF_FFF0;
         if ($urandom_range(0, 4) == 0) rp[1:0] = 2'($urandom_range(1, 3));
         redirect_pc = rp;
         tick();
         checks++;
         if (s_rv !== e_rv || (e_rv && s_ra !== e_ra))
            begin errors++; $display("FAIL rand_req cyc=%0d got=%b/%h want=%b/%h", cyc, s_rv, s_ra, e_rv, e_ra); end
         checks++;
         if (s_iv !== e_iv || (e_iv && (s_ip !== e_ip || s_i !== e_i)))
            begin errors++; $display("FAIL rand_inst cyc=%0d got=%b %h/%h want=%b %h/%h", cyc, s_iv, s_ip, s_i, e_iv, e_ip, e_i); end
`ifdef IFETCH_MISALIGN_EN
         checks++;
         if (s_mis !== e_mis)
            begin errors++; $display("FAIL rand_misalign cyc=%0d got=%b want=%b", cyc, s_mis, e_mis); end
`endif
      end
      reset_n = 1'b1; redirect = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; cyc = 0; last_due = 0;
      m_pc = RPC; m_halted = 1'b0;
      reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b0; inst_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      lat_min = 1; lat_max = 1; data_is_addr = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect_stale();
      test_redirect_same_cycle();
      test_wrap();
`ifdef IFETCH_MISALIGN_EN
      test_misalign();
`else
      test_align_force();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage that sits directly upstream of the decoder. It owns the fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel with an in-order response channel. It buffers returned words with their PCs in a small FIFO and presents them to the decoder over a valid/ready handshake. On a redirect from jump/branch resolution it flushes the FIFO, discards in-flight responses, and restarts fetch at the new PC.

## Interface
Parameters:
- XLEN, 32, address/PC width
- RESET_PC, 0, PC fetched first after reset
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, ≥2; also the cap on outstanding requests

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  word address of the request, always 4-aligned
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  XLEN  restart PC
- inst_valid  out  1  FIFO head valid
- inst  out  32  FIFO head instruction, feeds decoder inst
- inst_pc  out  XLEN  PC of FIFO head
- inst_ready  in  1  decoder consumes head this cycle
- misalign  out  1  only with IFETCH_MISALIGN_EN; see Configuration

## Operation
- State: pc, FIFO (entries {pc, inst}, count), outstanding counter, discard counter.
- Credit: imem_req_valid = !redirect && !halted && (outstanding + count < FIFO_DEPTH). Guarantees FIFO cannot overflow.
- imem_req_addr = pc. Request accepted (valid && ready): pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
- Address is stable while valid is high and not accepted. valid drops without acceptance only on a redirect.
- Response, discard == 0: push {pc of matching request, data}. The PC comes from a parallel tag FIFO or from the head PC plus 4×count. outstanding -= 1.
- Response, discard > 0: drop, discard -= 1, outstanding -= 1.
- Pop when inst_valid && inst_ready. Simultaneous push and pop are allowed at any count, including full.
- Redirect (highest priority):
  - pc ← redirect_pc; FIFO emptied; no pop is counted.
  - discard ← outstanding − (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is itself dropped.
  - outstanding keeps tracking the dropped responses.
- Fetch at the new PC may issue while discard > 0; in-order return keeps the discard accounting exact.

## Timing
- Reset cycle (reset_n = 0 at edge):
  - pc = RESET_PC; FIFO, outstanding, discard = 0.
  - imem_req_valid = 0, inst_valid = 0, misalign = 0.
  - Reset mid-operation abandons all in-flight requests; memory is reset with the core.
- First cycle after reset release: imem_req_valid = 1, imem_req_addr = RESET_PC.
- Latency: request accepted in cycle N, response in N+k (k ≥ 1), inst_valid in N+k+1. No combinational path from resp to inst.
- Redirect asserted in cycle N:
  - imem_req_valid = 0 in N.
  - inst_valid = 0 in N+1; imem_req_valid = 1 with addr = redirect_pc in N+1.
- Back-to-back redirects: the latest one wins; discard is recomputed each time.
- Steady state, with 1-cycle memory and FIFO_DEPTH = 2: one instruction per cycle when inst_ready stays high.

## Configuration
- IFETCH_MISALIGN_EN defined:
  - A redirect with redirect_pc[1:0] ≠ 0 sets the sticky halted state and drives misalign = 1.
  - While halted: imem_req_valid = 0, and inst_valid = 0 after the flush.
  - Cleared by an aligned redirect (fetch resumes at the next cycle) or by reset.
- IFETCH_MISALIGN_EN undefined:
  - misalign port absent; redirect_pc[1:0] forced to 0; never halts.

## Test plan
- Reset release, RESET_PC=0x100, 1-cycle memory returning addr as data, inst_ready=1 -> inst_pc 0x100,0x104,0x108 on consecutive cycles from cycle 3, inst==inst_pc.
- inst_ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 requests issued, imem_req_valid low after; on release, PCs 0x100,0x104,0x108 in order with no gaps or duplicates.
- imem_req_ready low for 5 cycles -> imem_req_valid stays high with addr held at 0x104; no pc advance.
- Memory latency 3, redirect to 0x400 with 2 outstanding -> both stale responses dropped; first inst_pc after redirect is 0x400; no 0x10x PC ever emitted afterwards.
- Redirect in the same cycle as imem_resp_valid and inst_ready -> response dropped, FIFO empty next cycle, discard = outstanding − 1.
- With IFETCH_MISALIGN_EN, redirect to 0x402 -> misalign=1, no requests; then redirect to 0x500 -> misalign=0, request at 0x500 next cycle.
